parallel_adder: RTL and testbench
=================================

// Module: parallel_adder
// PURPOSE
//   Registered 3-bit parallel (ripple-carry) adder with carry-in, wrapped in the
//   standard TinyTapeout user-project pin interface. Adds two 3-bit operands from
//   the dedicated inputs and drives sum, carry and status flags onto the dedicated outputs.
//   A free-running cycle counter drives a heartbeat output that shows the clock is alive.
// PARAMETERS
//   MAX_COUNT  10_000_000  heartbeat period in clk cycles; integer >= 2; the simulation bench uses 1000
// PORTS
//   clk      in   1  single clock; all state changes on rising edge
//   rst_n    in   1  reset, SYNCHRONOUS, ACTIVE-HIGH (1 = reset), sampled on clk rising edge
//   ena      in   1  design enable; 0 = all registers hold their value (reset still applies)
//   ui_in    in   8  [2:0]=A, [5:3]=B, [6]=Cin, [7]=hold (1 = freeze result registers)
//   uo_out   out  8  [2:0]=Sum, [3]=Cout, [4]=zero, [5]=max, [6]=heartbeat, [7]=valid
//   uio_in   in   8  unused, ignored
//   uio_out  out  8  constant 8'h00
//   uio_oe   out  8  constant 8'h00 (all bidirectional pins are inputs)
// BEHAVIOUR
//   - Interface: one clock; reset is synchronous and active-high (port rst_n, asserted = 1).
//   - Reset (rst_n=1 at a clk edge): Sum=0, Cout=0, zero=0, max=0, heartbeat=0,
//     valid=0, counter=0. The reset state is visible on uo_out immediately after that edge.
//     Reset overrides ena and hold.
//   - Arithmetic: {Cout,Sum} = A + B + Cin as a 4-bit unsigned value (range 0..15).
//     Built as three chained full adders: s_i = a_i^b_i^c_i, c_i+1 = a_i&b_i | c_i&(a_i^b_i),
//     with c_0 = Cin. No truncation other than the 4-bit result width.
//   - Latency: 1 cycle. Operands sampled at edge N appear on uo_out after edge N.
//     The adder is combinational and the result registers are loaded on each enabled edge.
//   - Load condition: ena=1 and hold=0 -> Sum/Cout/zero/max load the new values and valid<=1.
//     Otherwise these registers keep their values.
//   - zero = ({Cout,Sum} == 4'd0); max = ({Cout,Sum} == 4'd15). Both are registered with the sum.
//   - valid: 0 after reset, set by the first load, stays set until the next reset.
//   - Counter: width $clog2(MAX_COUNT) with a minimum of 1. It increments when ena=1 and is
//     independent of hold. At MAX_COUNT-1 it wraps to 0 and heartbeat toggles on that same edge.
//     This gives a period of 2*MAX_COUNT cycles.
//   - ena=0: counter and heartbeat hold; no load takes place.
//   - Reset mid-operation: all state returns to reset values on that edge with no partial update.
//   - uio_out/uio_oe are constant zero and never depend on state.
// TESTING
//   1. Assert rst_n=1 for 2 cycles, then release -> uo_out=8'h00 and uio_oe=8'h00.
//   2. ena=1, A=3, B=4, Cin=0 -> after 1 edge: Sum=7, Cout=0, zero=0, max=0, valid=1.
//   3. A=7, B=7, Cin=1 -> Sum=7, Cout=1, max=1. Then A=1, B=7, Cin=0 -> Sum=0, Cout=1, zero=0.
//   4. A=0, B=0, Cin=0 -> zero=1. Then set hold=1 and apply A=5, B=1 -> outputs keep Sum=0, zero=1.
//      Clear hold -> Sum=6 after 1 edge.
//   5. MAX_COUNT=1000, ena=1 from reset -> heartbeat rises on edge 1000 and falls on edge 2000.
//      With ena=0 for 10 cycles the toggle shifts by 10.
//   6. Exhaustive: all 128 (A,B,Cin) combinations -> {Cout,Sum} equals A+B+Cin one cycle later.

Source files
------------

// File: rtl/parallel_adder.sv
// parallel_adder
//   Registered 3-bit ripple-carry adder with carry-in. It uses the TinyTapeout
//   user-project pin interface. The two operands and carry-in come from the
//   dedicated inputs. The registered sum, carry-out and status flags drive the
//   dedicated outputs. A free-running cycle counter toggles a heartbeat output,
//   which shows that the clock is running.
//
// Ports
//   clk      in   1  single clock, rising edge
//   rst_n    in   1  synchronous reset, active HIGH despite the name (1 = reset)
//   ena      in   1  design enable; 0 = all registers hold (reset still applies)
//   ui_in    in   8  [2:0]=A, [5:3]=B, [6]=Cin, [7]=hold (1 = freeze result)
//   uo_out   out  8  [2:0]=Sum, [3]=Cout, [4]=zero, [5]=max, [6]=heartbeat, [7]=valid
//   uio_in   in   8  unused
//   uio_out  out  8  constant 0
//   uio_oe   out  8  constant 0 (all bidirectional pins are inputs)
//
// Output qualification: valid (uo_out[7]) is 0 from reset until the first
// edge with ena=1 and hold=0. It then stays 1 until the next reset. Each such
// edge loads a new result, and that result is visible right after the edge.
// There is no backpressure.

module parallel_adder #(
  parameter int MAX_COUNT = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW_RAW = $clog2(MAX_COUNT);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_COUNT - 1);

  // Operand fields
  logic [2:0] op_a;
  logic [2:0] op_b;
  logic       cin;
  logic       hold;

  assign op_a = ui_in[2:0];
  assign op_b = ui_in[5:3];
  assign cin  = ui_in[6];
  assign hold = ui_in[7];

  // Ripple-carry chain: carry[0] is Cin, and carry[3] is the carry-out.
  logic [3:0] carry;
  logic [2:0] sum_c;
  logic [3:0] res_c;
  logic       zero_c;
  logic       max_c;

  always_comb begin
    carry    = 4'd0;
    sum_c    = 3'd0;
    carry[0] = cin;
    for (int i = 0; i < 3; i++) begin
      sum_c[i]     = op_a[i] ^ op_b[i] ^ carry[i];
      carry[i + 1] = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
    end
  end

  assign res_c  = {carry[3], sum_c};
  assign zero_c = (res_c == 4'd0);
  assign max_c  = (res_c == 4'd15);

  // Result registers
  logic [2:0] sum_q;
  logic       cout_q;
  logic       zero_q;
  logic       max_q;
  logic       valid_q;
  logic       load;

  assign load = ena & ~hold;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sum_q   <= 3'd0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      max_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (load) begin
      sum_q   <= sum_c;
      cout_q  <= carry[3];
      zero_q  <= zero_c;
      max_q   <= max_c;
      valid_q <= 1'b1;
    end
  end

  // Heartbeat counter. It advances on every enabled edge, whatever hold is.
  // When it wraps it also toggles the heartbeat, so one heartbeat period is
  // 2*MAX_COUNT enabled cycles.
  logic [CW-1:0] cnt_q;
  logic          heartbeat_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q       <= '0;
      heartbeat_q <= 1'b0;
    end else if (ena) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q       <= '0;
        heartbeat_q <= ~heartbeat_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign uo_out  = {valid_q, heartbeat_q, max_q, zero_q, cout_q, sum_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // The bidirectional inputs are intentionally ignored.
  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in};

endmodule

// File: tb/tb_parallel_adder.sv
// tb_parallel_adder
//   Bench for parallel_adder with MAX_COUNT=1000. A driver task applies one
//   vector per cycle and pushes the hand-computed expected
//   {valid,max,zero,Cout,Sum} into exp_q. A monitor pops one entry after each
//   rising edge and compares it with uo_out, ignoring the heartbeat bit.
//   The heartbeat timing and the reset state are checked inline.

module tb_parallel_adder;

  localparam int MAX_COUNT = 1000;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] exp_q[$];

  parallel_adder #(.MAX_COUNT(MAX_COUNT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Hold reset for two edges, check the reset state, then release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_uo_out", {24'd0, uo_out}, 32'h00);
    check("reset_uio_oe", {24'd0, uio_oe}, 32'h00);
    check("reset_uio_out", {24'd0, uio_out}, 32'h00);
    rst_n = 1'b0;
  endtask

  // Driver: apply one vector for the next edge and queue its expected result.
  task automatic drive(input logic en, input logic hold, input logic cin,
                       input logic [2:0] b, input logic [2:0] a,
                       input logic [6:0] exp);
    @(negedge clk);
    ena   = en;
    ui_in = {hold, cin, b, a};
    exp_q.push_back(exp);
  endtask

  // Monitor: the result of each driven vector appears right after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [6:0] e;
      e = exp_q.pop_front();
      check("result", {25'd0, uo_out[7], uo_out[5:0]}, {25'd0, e});
    end
  end

  // Run from a fresh reset with ena=1, except for gap_len edges after
  // gap_start. Record the edge numbers of the heartbeat rise and fall.
  task automatic run_hb(input int gap_start, input int gap_len,
                        output int rise, output int fall);
    logic prev;
    rise = -1;
    fall = -1;
    prev = 1'b0;
    ui_in = 8'h00;
    ena   = 1'b1;
    do_reset();
    for (int e = 1; e <= 2 * MAX_COUNT + 50; e++) begin
      ena = !(e > gap_start && e <= gap_start + gap_len);
      @(posedge clk);
      #1;
      if (!prev && uo_out[6] && rise < 0) rise = e;
      if (prev && !uo_out[6] && fall < 0) fall = e;
      prev = uo_out[6];
      @(negedge clk);
    end
  endtask

  initial begin
    int rise;
    int fall;
    int s;
    rst_n  = 1'b0;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'hA5;

    do_reset();

    // hold=1 straight after reset: nothing loads, and valid stays 0.
    drive(1, 1, 0, 3'd4, 3'd3, 7'b0000000);
    // ena=0: nothing loads.
    drive(0, 0, 0, 3'd4, 3'd3, 7'b0000000);
    // 3+4+0 = 7
    drive(1, 0, 0, 3'd4, 3'd3, 7'b1000111);
    // 7+7+1 = 15, so max is set.
    drive(1, 0, 1, 3'd7, 3'd7, 7'b1101111);
    // 1+7+0 = 8: Sum=0 with Cout=1, so zero stays clear.
    drive(1, 0, 0, 3'd7, 3'd1, 7'b1001000);
    // 0+0+0 = 0, so zero is set.
    drive(1, 0, 0, 3'd0, 3'd0, 7'b1010000);
    // hold=1 with 5+1: the previous result is kept.
    drive(1, 1, 0, 3'd1, 3'd5, 7'b1010000);
    drive(1, 1, 0, 3'd1, 3'd5, 7'b1010000);
    // hold cleared: 5+1 = 6
    drive(1, 0, 0, 3'd1, 3'd5, 7'b1000110);
    // ena=0 with new operands: the result holds.
    drive(0, 0, 1, 3'd7, 3'd7, 7'b1000110);
    // carry-in only: 0+0+1 = 1
    drive(1, 0, 1, 3'd0, 3'd0, 7'b1000001);
    // 7+0+1 = 8
    drive(1, 0, 1, 3'd0, 3'd7, 7'b1001000);

    // Exhaustive sweep over all (A,B,Cin) combinations.
    for (int v = 0; v < 128; v++) begin
      logic [3:0] r;
      s = (v & 7) + ((v >> 3) & 7) + ((v >> 6) & 1);
      r = s[3:0];
      drive(1, 0, v[6], v[5:3], v[2:0], {1'b1, r == 4'd15, r == 4'd0, r});
    end

    // Reset overrides hold in the middle of operation.
    @(negedge clk);
    ena   = 1'b1;
    ui_in = 8'hFF;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_over_hold", {24'd0, uo_out}, 32'h00);
    @(negedge clk);
    rst_n = 1'b0;

    // Let the scoreboard drain; anything left over counts as a failure.
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();

    // Heartbeat with ena held high: rises on edge 1000, falls on edge 2000.
    run_hb(0, 0, rise, fall);
    check("hb_rise", rise, MAX_COUNT);
    check("hb_fall", fall, 2 * MAX_COUNT);

    // With 10 disabled edges partway through, both toggles move out by 10.
    run_hb(500, 10, rise, fall);
    check("hb_rise_gap", rise, MAX_COUNT + 10);
    check("hb_fall_gap", fall, 2 * MAX_COUNT + 10);

    check("uio_oe_const", {24'd0, uio_oe}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
